reg_bank_wb: RTL and testbench
==============================

// Module: reg_bank_wb
// PURPOSE
//  32x32 general-purpose register bank for the multicycle MIPS core; write port consumes the
//  destination index chosen by the destination-select mux (rt/rd/$29/$31/rs) at write-back.
//  Two read ports (rs, rt) serve decode. A per-register busy scoreboard marks destinations
//  reserved by in-flight multi-cycle instructions; the control FSM holds decode while a source
//  register is busy.
// PARAMETERS
//  SP_INIT    32'd227  reset value of $29 (stack pointer)
//  RA_INIT    32'd0    reset value of $31 (return address)
// PORTS
//  clk        in   1   core clock; all state changes on rising edge
//  reset      in   1   synchronous, active-high reset
//  rd_addr_a  in   5   read port A index (inst[25:21])
//  rd_addr_b  in   5   read port B index (inst[20:16])
//  rd_data_a  out  32  read port A data
//  rd_data_b  out  32  read port B data
//  busy_a     out  1   register at rd_addr_a has a pending write
//  busy_b     out  1   register at rd_addr_b has a pending write
//  rsv_en     in   1   reserve rsv_addr as a pending destination (decode of multi-cycle op)
//  rsv_addr   in   5   destination index to reserve
//  wr_en      in   1   write-back strobe
//  wr_addr    in   5   write-back destination index (from destination-select mux)
//  wr_data    in   32  write-back data
//  busy_cnt   out  6   number of registers currently busy (0..31)
// BEHAVIOUR
//  - Single clock, clk; reset is synchronous and active-high: on a clk edge with reset=1, all
//    regs <= 0 except $29 <= SP_INIT and $31 <= RA_INIT. All busy bits <= 0; busy_cnt <= 0.
//    reset wins over any same-cycle wr_en/rsv_en. Mid-operation reset discards pending
//    reservations.
//  - Write: edge with wr_en=1, wr_addr!=0 -> reg[wr_addr] <= wr_data, busy[wr_addr] <= 0.
//    Latency 1 cycle; data visible on read ports the cycle after the edge.
//  - $0: hardwired zero. Writes are ignored, reservations are ignored, busy[0] is always 0,
//    and reads of $0 always return 0.
//  - Reserve: edge with rsv_en=1, rsv_addr!=0 -> busy[rsv_addr] <= 1. Reserving an already
//    busy register is legal; it stays busy and busy_cnt is unchanged.
//  - Simultaneous rsv_en and wr_en to the same nonzero index: reserve wins, so the reg is
//    written and busy stays 1 (the new producer is pending).
//  - Simultaneous rsv_en and wr_en to different indices: both take effect, so busy_cnt
//    changes by +1-1 = 0 where applicable.
//  - A write to a non-busy register is legal (single-cycle ops never reserve). busy bit
//    stays 0.
//  - Reads are combinational from the array (and scoreboard); rd_addr_a == rd_addr_b is
//    legal.
//  - busy_cnt is a registered popcount maintained incrementally: +1 on a 0->1 transition,
//    -1 on a 1->0 transition, net on the same edge. It never wraps; 31 is the max.
// CONFIGURATION
//  REG_BANK_BYPASS_EN defined: write-to-read bypass. If wr_en=1, wr_addr!=0 and
//    wr_addr==rd_addr_x, then rd_data_x = wr_data and busy_x = 0 in the same cycle
//    (unless rsv_en targets the same index on that cycle, in which case busy_x=1).
//  Undefined: read ports show pre-edge contents; busy_x reflects registered state only.
//    The control FSM spends one extra decode cycle after a write-back to a source register.
// STRUCTURE
//  - cpu_pkg: REG_ADDR_W=5, WORD_W=32, NUM_REGS=32, REG_ZERO=5'd0, REG_SP=5'd29,
//    REG_RA=5'd31, typedefs reg_addr_t (logic[4:0]) and word_t (logic[31:0]).
//  - Sub-module reg_scoreboard: busy vector, reserve/clear arbitration and busy_cnt.
//    The top level holds the storage array and the read muxing/bypass.
// TESTING
//  1 reset, then read $29/$31/$5 -> 227 / 0 / 0; busy_a=busy_b=0; busy_cnt=0.
//  2 wr_en, wr_addr=0, wr_data=32'hDEAD_BEEF; then read $0 -> 0. Also rsv $0 -> busy_cnt
//    stays 0.
//  3 rsv $8 -> busy_a=1 when rd_addr_a=8, busy_cnt=1. Then wr $8=32'h1234 -> next cycle
//    rd_data_a=32'h1234, busy_a=0, busy_cnt=0.
//  4 same edge: rsv $9 + wr $9=7 -> reg $9=7, busy[9]=1, busy_cnt=1. Same edge: rsv $10 +
//    wr $9 -> busy_cnt stays 1, with busy[10]=1.
//  5 bypass: rd_addr_b=12, wr_en, wr_addr=12, wr_data=99 in the same cycle -> rd_data_b=99
//    with REG_BANK_BYPASS_EN, old value without it.
//  6 rsv $3, $4, $5, then reset asserted for one edge -> all busy=0, busy_cnt=0, $29=227,
//    and a concurrent wr $3 is dropped.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file widths, indices and types
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WORD_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [WORD_W-1:0]     word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_SP   = 5'd29;
  localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy bits with reserve/clear arbitration and busy count
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                rsv_en,
  input  reg_addr_t           rsv_addr,
  input  logic                wr_en,
  input  reg_addr_t           wr_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic [5:0]          busy_cnt
);

  logic [NUM_REGS-1:0] busy_nxt;
  logic                rsv_hit;
  logic                wr_hit;
  logic                cnt_inc;
  logic                cnt_dec;

  // Next busy vector: write-back clears, a same-edge reservation then re-sets (new producer wins).
  always_comb begin
    rsv_hit  = rsv_en && (rsv_addr != REG_ZERO);
    wr_hit   = wr_en && (wr_addr != REG_ZERO);
    busy_nxt = busy;
    if (wr_hit) busy_nxt[wr_addr] = 1'b0;
    if (rsv_hit) busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[REG_ZERO] = 1'b0;
    // Count only real transitions so the popcount tracks the vector without wrapping.
    cnt_inc = rsv_hit && !busy[rsv_addr];
    cnt_dec = wr_hit && busy[wr_addr] && !(rsv_hit && (rsv_addr == wr_addr));
  end

  // Scoreboard state: reset discards all outstanding reservations.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= busy_cnt + {5'd0, cnt_inc} - {5'd0, cnt_dec};
    end
  end

endmodule

// File: rtl/reg_bank_wb.sv
// rtl/reg_bank_wb.sv - 32x32 register bank with busy scoreboard; optional REG_BANK_BYPASS_EN write-to-read bypass
module reg_bank_wb
  import cpu_pkg::*;
#(
  parameter word_t SP_INIT = 32'd227,
  parameter word_t RA_INIT = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rd_addr_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_a,
  output logic [31:0] rd_data_b,
  output logic        busy_a,
  output logic        busy_b,
  input  logic        rsv_en,
  input  logic [4:0]  rsv_addr,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic [5:0]  busy_cnt
);

  word_t               regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  reg_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy     (busy),
    .busy_cnt (busy_cnt)
  );

  // Storage array: $0 is never written, $29/$31 come up with their architectural init values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      regs[REG_SP] <= SP_INIT;
      regs[REG_RA] <= RA_INIT;
    end else if (wr_en && (wr_addr != REG_ZERO)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports: combinational array/scoreboard lookup, optionally forwarding the write-back value.
  always_comb begin
    rd_data_a = (rd_addr_a == REG_ZERO) ? '0 : regs[rd_addr_a];
    rd_data_b = (rd_addr_b == REG_ZERO) ? '0 : regs[rd_addr_b];
    busy_a    = busy[rd_addr_a];
    busy_b    = busy[rd_addr_b];
`ifdef REG_BANK_BYPASS_EN
    if (wr_en && (wr_addr != REG_ZERO) && (wr_addr == rd_addr_a)) begin
      rd_data_a = wr_data;
      busy_a    = rsv_en && (rsv_addr == wr_addr);
    end
    if (wr_en && (wr_addr != REG_ZERO) && (wr_addr == rd_addr_b)) begin
      rd_data_b = wr_data;
      busy_b    = rsv_en && (rsv_addr == wr_addr);
    end
`endif
  end

endmodule

// File: tb/tb_reg_bank_wb.sv
// tb/tb_reg_bank_wb.sv - scoreboard bench for reg_bank_wb with a behavioural register-file model
module tb_reg_bank_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr_a, rd_addr_b, rsv_addr, wr_addr;
  logic [31:0] rd_data_a, rd_data_b, wr_data;
  logic        busy_a, busy_b, rsv_en, wr_en;
  logic [5:0]  busy_cnt;

  reg_bank_wb dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy_cnt  (busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] da;
    logic [31:0] db;
    logic        ba;
    logic        bb;
    logic [5:0]  cnt;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  bit          done     = 0;

  // Reference model of the architectural state.
  logic [31:0] m_regs [32];
  bit          m_busy [32];

  function automatic int popcount();
    int n = 0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    return m_regs[a];
  endfunction

  task automatic cmp(input string tag, input string field, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s %s got=%0h want=%0h", tag, field, got, want);
    end
  endtask

  // Monitor: DUT outputs are stable at the falling edge; compare against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        cmp(e.tag, "rd_data_a", rd_data_a, e.da);
        cmp(e.tag, "rd_data_b", rd_data_b, e.db);
        cmp(e.tag, "busy_a", {31'd0, busy_a}, {31'd0, e.ba});
        cmp(e.tag, "busy_b", {31'd0, busy_b}, {31'd0, e.bb});
        cmp(e.tag, "busy_cnt", {26'd0, busy_cnt}, {26'd0, e.cnt});
      end
    end
  end

  // Drive one cycle's inputs, queue the expected outputs, then advance the model over the edge.
  task automatic cycle(input bit rst, input logic [4:0] ra, input logic [4:0] rb,
                       input bit ren, input logic [4:0] raddr,
                       input bit wen, input logic [4:0] waddr, input logic [31:0] wd,
                       input bit chk, input string tag);
    exp_t e;
    reset     = rst;
    rd_addr_a = ra;
    rd_addr_b = rb;
    rsv_en    = ren;
    rsv_addr  = raddr;
    wr_en     = wen;
    wr_addr   = waddr;
    wr_data   = wd;
    if (chk) begin
      e.da  = model_read(ra);
      e.db  = model_read(rb);
      e.ba  = m_busy[ra];
      e.bb  = m_busy[rb];
      e.cnt = 6'(popcount());
`ifdef REG_BANK_BYPASS_EN
      if (wen && waddr != 5'd0 && waddr == ra) begin
        e.da = wd;
        e.ba = ren && (raddr == waddr);
      end
      if (wen && waddr != 5'd0 && waddr == rb) begin
        e.db = wd;
        e.bb = ren && (raddr == waddr);
      end
`endif
      e.tag = tag;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'd0;
        m_busy[i] = 0;
      end
      m_regs[29] = 32'd227;
      m_regs[31] = 32'd0;
    end else begin
      if (wen && waddr != 5'd0) begin
        m_regs[waddr] = wd;
        m_busy[waddr] = 0;
      end
      if (ren && raddr != 5'd0) m_busy[raddr] = 1;
    end
    #1;
  endtask

  initial begin
    // Power-up reset; outputs are unknown before it, so nothing is checked.
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, "init");
    // 1: reset values
    cycle(0, 29, 31, 0, 0, 0, 0, 0, 1, "reset_sp_ra");
    cycle(0, 5, 0, 0, 0, 0, 0, 0, 1, "reset_r5");
    // 2: $0 ignores writes and reservations
    cycle(0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 1, "wr_zero");
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 1, "read_zero");
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, "rsv_zero");
    // 3: reserve then write-back clears
    cycle(0, 8, 8, 1, 8, 0, 0, 0, 1, "pre_rsv8");
    cycle(0, 8, 0, 0, 0, 1, 8, 32'h1234, 1, "rsv8_busy");
    cycle(0, 8, 8, 0, 0, 0, 0, 0, 1, "wr8_clear");
    // 4: same-edge reserve and write
    cycle(0, 9, 10, 1, 9, 1, 9, 32'd7, 1, "rsv_wr9");
    cycle(0, 9, 10, 1, 10, 1, 9, 32'd11, 1, "same9_result");
    cycle(0, 9, 10, 0, 0, 0, 0, 0, 1, "rsv10_wr9");
    // 5: write to a register while it is being read
    cycle(0, 3, 12, 0, 0, 1, 12, 32'd99, 1, "bypass12");
    cycle(0, 12, 12, 0, 0, 0, 0, 0, 1, "after_wr12");
    // 6: reservations discarded by reset; concurrent write dropped
    cycle(0, 3, 4, 1, 3, 0, 0, 0, 1, "rsv3");
    cycle(0, 3, 4, 1, 4, 0, 0, 0, 1, "rsv4");
    cycle(0, 5, 4, 1, 5, 0, 0, 0, 1, "rsv5");
    cycle(1, 3, 29, 1, 6, 1, 3, 32'h5555, 1, "reset_mid");
    cycle(0, 3, 29, 0, 0, 0, 0, 0, 1, "post_reset");
    cycle(0, 5, 4, 0, 0, 0, 0, 0, 1, "post_reset_busy");
    // Randomized traffic, narrow address range half the time to force collisions.
    for (int n = 0; n < 600; n++) begin
      bit          narrow;
      logic [4:0]  ra, rb, rsa, wa;
      narrow = ($urandom_range(0, 1) == 1);
      ra  = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      rb  = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      rsa = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wa  = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      cycle(($urandom_range(0, 79) == 0), ra, rb, ($urandom_range(0, 2) != 0), rsa,
            ($urandom_range(0, 1) == 1), wa, $urandom, 1, "random");
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, "drain");
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
